cont_anel_param: RTL and testbench
==================================

# cont_anel_param

Parametrised successor to the 4-bit ring counter used on the DE2 test top level. It implements an N-bit ring, Johnson (twisted-ring) or serial-shift register with direction control, synchronous parallel load, an internal programmable step prescaler for visible stepping from CLOCK_50, and illegal-state self-correction. It sits between switch/key inputs and the LEDR/HEX outputs of a board top level, or inside larger sequencers as a one-hot/Johnson phase generator.

## Interface
- N, 8, register width; legal range 2..32
- DIV_W, 26, prescaler counter width
- ck  in  1  rising-edge clock
- clr  in  1  asynchronous, active-low reset
- en  in  1  count enable; gates the prescaler and all steps
- load  in  1  synchronous parallel load of d
- d  in  N  load value
- mode  in  2  00 ring, 01 Johnson, 10 shift, 11 hold
- dir  in  1  0 = left (toward MSB), 1 = right (toward LSB)
- sin  in  1  serial input, shift mode only
- div  in  DIV_W  step period minus one; 0 = step every enabled cycle
- q  out  N  register state
- tick  out  1  step strobe (combinational from prescaler state)
- wrap  out  1  registered one-cycle pulse, home state reached by a step
- err  out  1  registered one-cycle pulse, illegal state corrected

## Operation
- Reset (clr=0, async): q = 0…01, prescaler count = 0, wrap = 0, err = 0.
- Prescaler: count increments each cycle with en=1; tick = en & (count >= div); on tick count returns to 0. en=0 holds count. Lowering div below current count yields tick on the next enabled cycle.
- Priority per cycle: load > step > hold. load: q <= d, count <= 0, wrap/err <= 0, no legality check on d.
- Step (tick=1, load=0):
  - ring left {q[N-2:0], q[N-1]}; ring right {q[0], q[N-1:1]}
  - Johnson left {q[N-2:0], ~q[N-1]}; Johnson right {~q[0], q[N-1:1]}
  - shift left {q[N-2:0], sin}; shift right {sin, q[N-1:1]}
  - hold: q unchanged, wrap/err stay 0
- Legality, checked on current q at each step:
  - ring legal: exactly one bit set
  - Johnson legal: at most one adjacent-bit difference across bits 0..N-1 (non-circular), i.e. 2N states
  - shift/hold: always legal
- Illegal at step: instead of rotating, q <= home (ring 0…01, Johnson 0…0), err = 1 next cycle, wrap = 0.
- wrap = 1 for one cycle after a legal step whose result equals home (ring 0…01, Johnson 0…0); never in shift/hold.
- mode/dir changes take effect on the next step; a state illegal for the new mode is corrected on that step with err.

## Timing
- q, wrap, err update on the rising ck edge ending the tick cycle; latency tick→q is 1 edge.
- div=0, en=1: one step per clock; period of ring = N cycles, Johnson = 2N cycles.
- div=k: one step per k+1 enabled cycles.
- clr asserted mid-operation: immediate reset; first tick after release no earlier than div+1 enabled cycles.
- load and tick same cycle: load wins, step discarded, prescaler restarted.

## Structure
- Package cont_pkg: mode constants MODE_RING, MODE_JOHNSON, MODE_SHIFT, MODE_HOLD; dir constants DIR_LEFT, DIR_RIGHT.
- Sub-module div_tick (parameter DIV_W): ports ck, clr, en, clear, div, tick. Top instantiates it once; next-state, legality and wrap logic stay in cont_anel_param.

## Test plan
- N=4, div=0, mode ring, dir left, en=1 after reset: q 0001→0010→0100→1000→0001, wrap high only in the cycle after 0001 reappears.
- N=4, Johnson left: 0001→0011→0111→1111→1110→1100→1000→0000→0001; wrap after 0000; dir right from 0011 gives 0001.
- N=4, ring, load d=0110 then tick: q=0001, err=1 for one cycle, wrap=0.
- div=3, en=1: tick every 4th cycle; en=0 for 2 cycles mid-count stretches the interval to 6 cycles.
- Shift left, sin pattern 1,0,1,1 from q=0000: q=1011 after 4 ticks; no wrap/err.
- Load and tick same cycle with d=1000: q=1000, next tick div+1 cycles later; clr pulsed mid-run returns q=0001 asynchronously.

Source files
------------

// File: rtl/cont_pkg.sv
// Shared mode and direction encodings for the parametrised ring/Johnson/shift counter.
package cont_pkg;

  localparam logic [1:0] MODE_RING    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_SHIFT   = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/cont_anel_param_div_tick.sv
// Programmable step prescaler: tick strobes once every div+1 enabled cycles.
module div_tick #(
  parameter int DIV_W = 26
) (
  input  logic             ck,
  input  logic             clr,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // ">=" rather than "==" so lowering div below the count still fires promptly
  assign tick = en & (cnt_q >= div);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge ck or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cont_anel_param.sv
// N-bit ring / Johnson / serial-shift register with direction, parallel load,
// prescaled stepping and illegal-state correction back to the home state.
module cont_anel_param
  import cont_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 26
) (
  input  logic             ck,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [N-1:0]     d,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             sin,
  input  logic [DIV_W-1:0] div,
  output logic [N-1:0]     q,
  output logic             tick,
  output logic             wrap,
  output logic             err
);

  localparam logic [N-1:0] RING_HOME = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] JOHN_HOME = '0;

  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic [N-1:0] ring_nxt, john_nxt, shift_nxt;
  logic [N-2:0] edge_diff;
  logic         ring_ok, john_ok;

  div_tick #(.DIV_W(DIV_W)) u_div_tick (
    .ck    (ck),
    .clr   (clr),
    .en    (en),
    .clear (load),
    .div   (div),
    .tick  (tick)
  );

  assign ring_nxt  = (dir == DIR_RIGHT) ? {q_q[0], q_q[N-1:1]}  : {q_q[N-2:0], q_q[N-1]};
  assign john_nxt  = (dir == DIR_RIGHT) ? {~q_q[0], q_q[N-1:1]} : {q_q[N-2:0], ~q_q[N-1]};
  assign shift_nxt = (dir == DIR_RIGHT) ? {sin, q_q[N-1:1]}     : {q_q[N-2:0], sin};

  // Johnson codes have at most one transition between neighbouring bits
  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_edge
      assign edge_diff[gi] = q_q[gi+1] ^ q_q[gi];
    end
  endgenerate

  assign ring_ok = ($countones(q_q) == 1);
  assign john_ok = ($countones(edge_diff) <= 1);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      q_d = d;
    end else if (tick) begin
      case (mode)
        MODE_RING: begin
          if (ring_ok) begin
            q_d    = ring_nxt;
            wrap_d = (ring_nxt == RING_HOME);
          end else begin
            q_d   = RING_HOME;
            err_d = 1'b1;
          end
        end
        MODE_JOHNSON: begin
          if (john_ok) begin
            q_d    = john_nxt;
            wrap_d = (john_nxt == JOHN_HOME);
          end else begin
            q_d   = JOHN_HOME;
            err_d = 1'b1;
          end
        end
        MODE_SHIFT: q_d = shift_nxt;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge ck or negedge clr) begin
    if (!clr) begin
      q_q    <= RING_HOME;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_cont_anel_param.sv
// Bench for cont_anel_param (N=4): directed table, prescaler/load/reset sequences, random vs model.
module tb_cont_anel_param;
  import cont_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MASK = (1 << N) - 1;

  logic          ck = 1'b0;
  logic          clr, en, load, dir, sin;
  logic [N-1:0]  d;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic [N-1:0]  q;
  logic          tick, wrap, err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   m_q, m_cnt, m_w, m_e;
  logic last_tick;
  int   n;

  typedef struct {
    logic       load;
    logic [3:0] d;
    logic [1:0] mode;
    logic       dir;
    logic       sin;
    logic [3:0] eq;
    logic       ew;
    logic       ee;
  } vec_t;
  vec_t vq[$];

  cont_anel_param #(.N(N), .DIV_W(DW)) dut (
    .ck(ck), .clr(clr), .en(en), .load(load), .d(d), .mode(mode), .dir(dir),
    .sin(sin), .div(div), .q(q), .tick(tick), .wrap(wrap), .err(err)
  );

  always #5 ck = ~ck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc=%0d: actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit is_johnson(input int v);
    for (int k = 0; k <= N; k++) begin
      if (v == ((1 << k) - 1) || v == (MASK & ~((1 << k) - 1))) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference behaviour for one rising edge with the current inputs
  task automatic model_edge();
    int nq;
    bit mt;
    mt  = en && (m_cnt >= int'(div));
    m_w = 0;
    m_e = 0;
    if (load) begin
      m_q   = int'(d);
      m_cnt = 0;
    end else if (mt) begin
      m_cnt = 0;
      nq    = m_q;
      case (mode)
        MODE_RING: begin
          if ($countones(m_q) == 1) begin
            nq  = dir ? (((m_q >> 1) | (m_q << (N - 1))) & MASK)
                      : (((m_q << 1) | (m_q >> (N - 1))) & MASK);
            m_w = (nq == 1);
          end else begin
            nq  = 1;
            m_e = 1;
          end
        end
        MODE_JOHNSON: begin
          if (is_johnson(m_q)) begin
            nq  = dir ? ((m_q >> 1) | (((m_q & 1) ^ 1) << (N - 1)))
                      : (((m_q << 1) & MASK) | (((m_q >> (N - 1)) & 1) ^ 1));
            m_w = (nq == 0);
          end else begin
            nq  = 0;
            m_e = 1;
          end
        end
        MODE_SHIFT: nq = dir ? ((m_q >> 1) | (int'(sin) << (N - 1)))
                             : (((m_q << 1) & MASK) | int'(sin));
        default:    nq = m_q;
      endcase
      m_q = nq;
    end else if (en) begin
      m_cnt++;
    end
  endtask

  task automatic run_cycle(input logic i_en, input logic i_load, input logic [N-1:0] i_d,
                           input logic [1:0] i_mode, input logic i_dir, input logic i_sin,
                           input logic [DW-1:0] i_div);
    @(negedge ck);
    en = i_en; load = i_load; d = i_d; mode = i_mode; dir = i_dir; sin = i_sin; div = i_div;
    #1;
    chk("tick", 32'(tick), 32'(en && (m_cnt >= int'(div))));
    last_tick = tick;
    @(posedge ck);
    model_edge();
    #1;
    cyc++;
    chk("q", 32'(q), 32'(m_q));
    chk("wrap", 32'(wrap), 32'(m_w));
    chk("err", 32'(err), 32'(m_e));
    $display("cyc=%0d en=%b load=%b d=%b mode=%0d dir=%b sin=%b div=%0d tick=%b q=%b wrap=%b err=%b",
             cyc, en, load, d, mode, dir, sin, div, last_tick, q, wrap, err);
  endtask

  task automatic measure(input logic [1:0] i_mode, input logic [DW-1:0] i_div, output int cnt);
    cnt = 0;
    do begin
      run_cycle(1'b1, 1'b0, '0, i_mode, DIR_LEFT, 1'b0, i_div);
      cnt++;
    end while (!last_tick && cnt < 40);
  endtask

  task automatic add(input logic l, input logic [3:0] dv, input logic [1:0] md, input logic dr,
                     input logic s, input logic [3:0] eq, input logic ew, input logic ee);
    vec_t v;
    v = '{l, dv, md, dr, s, eq, ew, ee};
    vq.push_back(v);
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; load = 1'b0; d = '0; mode = MODE_RING;
    dir = DIR_LEFT; sin = 1'b0; div = '0;
    m_q = 1; m_cnt = 0; m_w = 0; m_e = 0;
    #12;
    chk("reset_q", 32'(q), 32'd1);
    chk("reset_wrap", 32'(wrap), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    clr = 1'b1;

    // Directed table, div=0, en=1
    add(0, 4'b0000, MODE_RING, DIR_LEFT, 0, 4'b0010, 0, 0);
    add(0, 4'b0000, MODE_RING, DIR_LEFT, 0, 4'b0100, 0, 0);
    add(0, 4'b0000, MODE_RING, DIR_LEFT, 0, 4'b1000, 0, 0);
    add(0, 4'b0000, MODE_RING, DIR_LEFT, 0, 4'b0001, 1, 0);
    add(0, 4'b0000, MODE_RING, DIR_LEFT, 0, 4'b0010, 0, 0);
    add(1, 4'b0001, MODE_JOHNSON, DIR_LEFT, 0, 4'b0001, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b0011, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b0111, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b1111, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b1110, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b1100, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b1000, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b0000, 1, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b0001, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b0011, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_RIGHT, 0, 4'b0001, 0, 0);
    add(1, 4'b0110, MODE_RING, DIR_LEFT, 0, 4'b0110, 0, 0);
    add(0, 4'b0000, MODE_RING, DIR_LEFT, 0, 4'b0001, 0, 1);
    add(0, 4'b0000, MODE_RING, DIR_LEFT, 0, 4'b0010, 0, 0);
    add(1, 4'b0000, MODE_SHIFT, DIR_LEFT, 0, 4'b0000, 0, 0);
    add(0, 4'b0000, MODE_SHIFT, DIR_LEFT, 1, 4'b0001, 0, 0);
    add(0, 4'b0000, MODE_SHIFT, DIR_LEFT, 0, 4'b0010, 0, 0);
    add(0, 4'b0000, MODE_SHIFT, DIR_LEFT, 1, 4'b0101, 0, 0);
    add(0, 4'b0000, MODE_SHIFT, DIR_LEFT, 1, 4'b1011, 0, 0);
    add(0, 4'b0000, MODE_HOLD, DIR_LEFT, 0, 4'b1011, 0, 0);
    add(0, 4'b0000, MODE_JOHNSON, DIR_LEFT, 0, 4'b0000, 0, 1);
    add(0, 4'b0000, MODE_JOHNSON, DIR_RIGHT, 0, 4'b1000, 0, 0);
    add(0, 4'b0000, MODE_RING, DIR_RIGHT, 0, 4'b0100, 0, 0);
    add(0, 4'b0000, MODE_RING, DIR_RIGHT, 0, 4'b0010, 0, 0);
    add(0, 4'b0000, MODE_RING, DIR_RIGHT, 0, 4'b0001, 1, 0);
    add(0, 4'b0000, MODE_RING, DIR_RIGHT, 0, 4'b1000, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      run_cycle(1'b1, vq[i].load, vq[i].d, vq[i].mode, vq[i].dir, vq[i].sin, '0);
      chk("tbl_q", 32'(q), 32'(vq[i].eq));
      chk("tbl_wrap", 32'(wrap), 32'(vq[i].ew));
      chk("tbl_err", 32'(err), 32'(vq[i].ee));
    end

    // Prescaler period with div=3, then an en gap stretching one interval
    run_cycle(1'b1, 1'b1, 4'b0001, MODE_RING, DIR_LEFT, 1'b0, 8'd3);
    measure(MODE_RING, 8'd3, n);
    chk("div3_interval", 32'(n), 32'd4);
    n = 0;
    run_cycle(1'b1, 1'b0, '0, MODE_RING, DIR_LEFT, 1'b0, 8'd3); n++;
    run_cycle(1'b0, 1'b0, '0, MODE_RING, DIR_LEFT, 1'b0, 8'd3); n++;
    run_cycle(1'b0, 1'b0, '0, MODE_RING, DIR_LEFT, 1'b0, 8'd3); n++;
    begin
      int extra;
      measure(MODE_RING, 8'd3, extra);
      n += extra;
    end
    chk("en_gap_interval", 32'(n), 32'd6);

    // Load coinciding with a tick
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, '0, MODE_RING, DIR_LEFT, 1'b0, 8'd3);
    run_cycle(1'b1, 1'b1, 4'b1000, MODE_RING, DIR_LEFT, 1'b0, 8'd3);
    chk("load_tick_tick", 32'(last_tick), 32'd1);
    chk("load_tick_q", 32'(q), 32'b1000);
    measure(MODE_RING, 8'd3, n);
    chk("after_load_interval", 32'(n), 32'd4);
    chk("after_load_q", 32'(q), 32'b0001);
    chk("after_load_wrap", 32'(wrap), 32'd1);

    // Asynchronous clear in the middle of a count
    run_cycle(1'b1, 1'b0, '0, MODE_RING, DIR_LEFT, 1'b0, 8'd3);
    run_cycle(1'b1, 1'b0, '0, MODE_RING, DIR_LEFT, 1'b0, 8'd3);
    #2;
    clr = 1'b0;
    #1;
    chk("clr_async_q", 32'(q), 32'd1);
    chk("clr_async_wrap", 32'(wrap), 32'd0);
    chk("clr_async_err", 32'(err), 32'd0);
    m_q = 1; m_cnt = 0; m_w = 0; m_e = 0;
    @(posedge ck);
    #1;
    chk("clr_held_q", 32'(q), 32'd1);
    clr = 1'b1;
    measure(MODE_RING, 8'd3, n);
    chk("clr_first_tick", 32'(n), 32'd4);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
                N'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                DW'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
